// File: rtl/bp_me_pkg.sv
// Shared types for the memory-end DMA responder.
// Holds the responder FSM state encoding.
package bp_me_pkg;

  typedef enum logic [1:0] {
    e_ready = 2'd0,
    e_read  = 2'd1,
    e_write = 2'd2
  } bp_me_dma_resp_state_e;

endpackage

// File: rtl/bsg_mem_1r1w.sv
// Backing store: asynchronous read, synchronous write.
// Contents are never reset.
module bsg_mem_1r1w #(
  parameter int width_p = 64,
  parameter int els_p   = 4096,
  localparam int lg_els_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                 w_clk_i,
  input  logic                 w_v_i,
  input  logic [lg_els_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]   w_data_i,
  input  logic [lg_els_lp-1:0] r_addr_i,
  output logic [width_p-1:0]   r_data_o
);

  logic [width_p-1:0] mem [els_p];

  // write port lands on the handshake edge
  always_ff @(posedge w_clk_i) begin
    if (w_v_i) mem[w_addr_i] <= w_data_i;
  end

  assign r_data_o = mem[r_addr_i];

endmodule

// File: rtl/bp_me_cache_dma_responder.sv
// Memory-side DMA endpoint for one cache bank.
// Streams fill beats for reads, stores eviction beats for writes.
module bp_me_cache_dma_responder
  import bp_me_pkg::*;
#(
  parameter int daddr_width_p = 28,
  parameter int fill_width_p  = 64,
  parameter int block_width_p = 512,
  parameter int mem_els_p     = 4096
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [daddr_width_p:0]   dma_pkt_i,
  input  logic                     dma_pkt_v_i,
  output logic                     dma_pkt_ready_and_o,
  output logic [fill_width_p-1:0]  dma_data_o,
  output logic                     dma_data_v_o,
  input  logic                     dma_data_ready_and_i,
  input  logic [fill_width_p-1:0]  dma_data_i,
  input  logic                     dma_data_v_i,
  output logic                     dma_data_ready_and_o
);

  localparam int beats_lp = block_width_p / fill_width_p;
  localparam int lg_beats_lp = (beats_lp > 1) ? $clog2(beats_lp) : 0;
  localparam int cnt_w_lp = (beats_lp > 1) ? $clog2(beats_lp) : 1;
  localparam int off_lp = $clog2(block_width_p / 8);
  localparam int aw_lp = (mem_els_p > 1) ? $clog2(mem_els_p) : 1;

  typedef struct packed {
    logic                     write_not_read;
    logic [daddr_width_p-1:0] addr;
  } bsg_cache_dma_pkt_s;

  bsg_cache_dma_pkt_s pkt;
  assign pkt = dma_pkt_i;

  bp_me_dma_resp_state_e state_r;
  logic [aw_lp-1:0]    blk_r;
  logic [cnt_w_lp-1:0] cnt_r;
  logic [aw_lp-1:0]    blk_n;
  logic [aw_lp-1:0]    word;
  logic pkt_hs, rd_hs, wr_hs, last;

  // block offset bits are dropped; excess index bits fall off in word
  assign blk_n = aw_lp'(pkt.addr >> off_lp);
  assign word = (blk_r << lg_beats_lp) | aw_lp'(cnt_r);

  logic unused_addr;
  assign unused_addr = ^pkt.addr;

  assign dma_pkt_ready_and_o  = (state_r == e_ready);
  assign dma_data_v_o         = (state_r == e_read);
  assign dma_data_ready_and_o = (state_r == e_write);

  assign pkt_hs = dma_pkt_v_i & dma_pkt_ready_and_o;
  assign rd_hs  = dma_data_v_o & dma_data_ready_and_i;
  assign wr_hs  = dma_data_v_i & dma_data_ready_and_o;
  assign last   = (cnt_r == cnt_w_lp'(beats_lp - 1));

  // burst sequencing: accept packet, count beats, return to ready
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= e_ready;
      cnt_r   <= '0;
    end else begin
      unique case (state_r)
        e_ready: if (pkt_hs) begin
          blk_r   <= blk_n;
          cnt_r   <= '0;
          state_r <= pkt.write_not_read ? e_write : e_read;
        end
        e_read: if (rd_hs) begin
          cnt_r <= cnt_r + 1'b1;
          if (last) state_r <= e_ready;
        end
        e_write: if (wr_hs) begin
          cnt_r <= cnt_r + 1'b1;
          if (last) state_r <= e_ready;
        end
        default: state_r <= e_ready;
      endcase
    end
  end

  bsg_mem_1r1w #(
    .width_p(fill_width_p),
    .els_p  (mem_els_p)
  ) mem (
    .w_clk_i (clk_i),
    .w_v_i   (wr_hs),
    .w_addr_i(word),
    .w_data_i(dma_data_i),
    .r_addr_i(word),
    .r_data_o(dma_data_o)
  );

endmodule
